// File: rtl/alu_iterative.sv
// rtl/alu_iterative.sv - RV32I execute ALU with valid/ready handshake and iterative shifter
// Build option: ALU_FAST_SHIFT_EN selects a single-cycle barrel shifter instead.
module alu_iterative #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_LUI   = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
`ifdef ALU_FAST_SHIFT_EN
        S_DONE  = 2'd1
`else
        S_DONE  = 2'd1,
        S_SHIFT = 2'd2
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] alu_res;
    logic [4:0]      shamt;

    assign shamt = op_b[4:0];

`ifndef ALU_FAST_SHIFT_EN
    logic [XLEN-1:0] shreg_q, shreg_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] shift_step;
    logic            is_shift;

    assign is_shift = (alu_control == OP_SLL) || (alu_control == OP_SRL) || (alu_control == OP_SRA);

    always_comb begin
        shift_step = shreg_q;
        case (op_q)
            OP_SLL:  shift_step = {shreg_q[XLEN-2:0], 1'b0};
            OP_SRL:  shift_step = {1'b0, shreg_q[XLEN-1:1]};
            default: shift_step = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
        endcase
    end
`endif

    // Single-cycle datapath; in the iterative build shift codes pass op_a (the shamt=0 result).
    always_comb begin
        alu_res = op_a + op_b;
        case (alu_control)
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $signed(op_a) >>> shamt;
`else
            OP_SLL, OP_SRL, OP_SRA: alu_res = op_a;
`endif
            OP_LUI:  alu_res = op_b;
            default: alu_res = op_a + op_b;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
`ifndef ALU_FAST_SHIFT_EN
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
`ifdef ALU_FAST_SHIFT_EN
                    result_d = alu_res;
                    state_d  = S_DONE;
`else
                    if (is_shift && (shamt != 5'd0)) begin
                        shreg_d = op_a;
                        cnt_d   = shamt;
                        op_d    = alu_control;
                        state_d = S_SHIFT;
                    end else begin
                        result_d = alu_res;
                        state_d  = S_DONE;
                    end
`endif
                end
            end
`ifndef ALU_FAST_SHIFT_EN
            S_SHIFT: begin
                shreg_d = shift_step;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_d = shift_step;
                    state_d  = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
`ifndef ALU_FAST_SHIFT_EN
            shreg_q  <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
`ifndef ALU_FAST_SHIFT_EN
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = (result_q == '0);
endmodule

// File: tb/tb_alu_iterative.sv
// tb/tb_alu_iterative.sv - scoreboard testbench for alu_iterative
// Honours ALU_FAST_SHIFT_EN for expected shift latency.
module tb_alu_iterative;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;
    exp_t sb[$];

    alu_iterative #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (c)
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return 32'(sa >>> b[4:0]);
            4'd10:   return b;
            default: return a + b;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
        return 1;
`else
        if (c == 4'd7 || c == 4'd8 || c == 4'd9) return int'(b[4:0]) + 1;
        return 1;
`endif
    endfunction

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input bit push, output bit to);
        exp_t e;
        alu_control = c; op_a = a; op_b = b; in_valid = 1'b1; to = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                @(posedge clk); #1;
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        // scramble operands so any late sampling shows up as a wrong result
        alu_control = 4'($urandom_range(0, 15)); op_a = $urandom; op_b = $urandom;
        if (!to && push) begin
            e.res = model(c, a, b);
            e.lat = model_lat(c, b);
            sb.push_back(e);
        end
    endtask

    task automatic collect(output logic [31:0] r, output logic z, output int lat, output bit to);
        lat = 1; to = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (out_valid) begin
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        r = result; z = zero;
        if (!to) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; alu_control = 4'd0; op_a = 32'd3; op_b = 32'd4; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL reset_out_valid cyc=%0d got=%b exp=0", i, out_valid);
            end
        end
        rst = 1'b0;
        checks++;
        if (result !== 32'd0 || zero !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_values got result=%h zero=%b in_ready=%b exp 0/1/1", result, zero, in_ready);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ops();
        logic [3:0]  ct[14] = '{4'd1, 4'd0, 4'd5, 4'd6, 4'd10, 4'd7, 4'd8, 4'd2, 4'd3,
                                4'd11, 4'd15, 4'd12, 4'd9, 4'd7};
        logic [31:0] at[14] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'd1,
                                32'h80000000, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00400000,
                                32'd7, 32'h7FFFFFFF, 32'h80000000, 32'h00000003};
        logic [31:0] bt[14] = '{32'd5, 32'd1, 32'd1, 32'd1, 32'h12345000, 32'h20,
                                32'd31, 32'hFF00FF00, 32'h0000F0F0, 32'h00001000,
                                32'd9, 32'd1, 32'd4, 32'd30};
        logic [31:0] r;
        logic        z;
        int          lat;
        bit          to;
        exp_t        e;
        for (int i = 0; i < 14; i++) begin
            issue(ct[i], at[i], bt[i], 1'b1, to);
            checks++;
            if (to) begin
                failures++; $display("FAIL ops_accept_timeout idx=%0d", i);
                continue;
            end
            // busy cycles must keep in_ready low
            while (!out_valid && in_ready === 1'b0 && lat < 40) begin
                @(posedge clk); #1;
            end
            collect(r, z, lat, to);
            e = sb.pop_front();
            checks++;
            if (to) begin
                failures++; $display("FAIL ops_result_timeout idx=%0d", i);
                continue;
            end
            checks++;
            if (r !== e.res) begin
                failures++; $display("FAIL ops_result idx=%0d ctrl=%0d got=%h exp=%h", i, ct[i], r, e.res);
            end
            checks++;
            if (z !== (e.res == 32'd0)) begin
                failures++; $display("FAIL ops_zero idx=%0d got=%b exp=%b", i, z, (e.res == 32'd0));
            end
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                failures++; $display("FAIL ops_post_handshake idx=%0d in_ready=%b out_valid=%b exp 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_shift_busy();
        bit          to;
        int          lat;
        exp_t        e;
        issue(4'd9, 32'h80000000, 32'd4, 1'b1, to);
        lat = 1;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++; $display("FAIL busy_in_ready cyc=%0d got=%b exp=0", i, in_ready);
            end
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || out_valid !== 1'b1) begin
            failures++; $display("FAIL sra_latency got=%0d exp=%0d out_valid=%b", lat, e.lat, out_valid);
        end
        checks++;
        if (result !== e.res) begin
            failures++; $display("FAIL sra_result got=%h exp=%h", result, e.res);
        end
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_latency();
        logic [3:0]  ct[4] = '{4'd7, 4'd8, 4'd9, 4'd4};
        logic [31:0] bt[4] = '{32'h20, 32'd31, 32'd1, 32'd31};
        logic [31:0] r;
        logic        z;
        int          lat;
        bit          to;
        exp_t        e;
        for (int i = 0; i < 4; i++) begin
            issue(ct[i], 32'h80000001, bt[i], 1'b1, to);
            collect(r, z, lat, to);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat) begin
                failures++; $display("FAIL latency idx=%0d got=%0d exp=%0d", i, lat, e.lat);
            end
            checks++;
            if (r !== e.res) begin
                failures++; $display("FAIL latency_result idx=%0d got=%h exp=%h", i, r, e.res);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        logic        z;
        int          lat;
        bit          to;
        exp_t        e;
        issue(4'd4, 32'h0000F0F0, 32'h00000FF0, 1'b1, to);
        @(posedge clk); #1;
        in_valid = 1'b1; alu_control = 4'd0; op_a = 32'd1; op_b = 32'd1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (result !== 32'h0000FF00 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure cyc=%0d result=%h out_valid=%b in_ready=%b exp 0000ff00/1/0", i, result, out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        collect(r, z, lat, to);
        e = sb.pop_front();
        checks++;
        if (r !== e.res) begin
            failures++; $display("FAIL backpressure_result got=%h exp=%h", r, e.res);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL backpressure_no_accept out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_abort();
        bit to;
        bit seen = 1'b0;
        issue(4'd7, 32'd1, 32'd20, 1'b0, to);
        for (int i = 0; i < 3; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || result !== 32'd0 || zero !== 1'b1) begin
            failures++; $display("FAIL abort_reset in_ready=%b result=%h zero=%b exp 1/0/1", in_ready, result, zero);
        end
        for (int i = 0; i < 30; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin
            failures++; $display("FAIL abort_out_valid got=1 exp=0");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic        z;
        int          lat;
        bit          to;
        exp_t        e;
        logic [3:0]  c;
        for (int i = 0; i < 20; i++) begin
            c = 4'($urandom_range(0, 15));
            issue(c, $urandom, $urandom, 1'b1, to);
            out_ready = 1'b1;
            collect(r, z, lat, to);
            e = sb.pop_front();
            checks++;
            if (to || r !== e.res || lat !== e.lat) begin
                failures++;
                $display("FAIL b2b idx=%0d ctrl=%0d got=%h lat=%0d exp=%h lat=%0d", i, c, r, lat, e.res, e.lat);
            end
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++; $display("FAIL b2b_done_one_cycle idx=%0d out_valid=%b in_ready=%b exp 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_shift_busy();
        test_latency();
        test_backpressure();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
